// File: rtl/face_sad_matcher_if.sv
// Registered 8-bit read port between face_sad_matcher and the image memory.
`timescale 1ns/1ps
interface face_sad_matcher_if;
    logic        mem_r_en;
    logic [17:0] mem_r_add;
    logic [7:0]  mem_r_data;

    modport master (
        output mem_r_en,
        output mem_r_add,
        input  mem_r_data
    );

    modport slave (
        input  mem_r_en,
        input  mem_r_add,
        output mem_r_data
    );
endinterface

// File: rtl/face_sad_matcher.sv
// Streams probe and template pixels from memory, accumulates per-face SAD
// and tracks the lowest-SAD face (ties keep the lower index).
`timescale 1ns/1ps
module face_sad_matcher #(
    parameter int PIXELS     = 64,
    parameter int FACES      = 4,
    parameter int PROBE_BASE = FACES * PIXELS,
    parameter int ID_W       = 2,
    parameter int SAD_W      = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    face_sad_matcher_if.master   mem,
    output logic                 busy,
    output logic                 face_sad_valid,
    output logic [SAD_W-1:0]     face_sad,
    output logic [ID_W-1:0]      best_id,
    output logic [SAD_W-1:0]     best_sad,
    output logic                 done
);

    localparam int IW = (PIXELS > 1) ? $clog2(PIXELS) : 1;
    localparam logic [IW-1:0]   I_LAST = IW'(PIXELS - 1);
    localparam logic [ID_W-1:0] F_LAST = ID_W'(FACES - 1);

    typedef enum logic [2:0] {
        IDLE, PROBE, TMPL, FIN, CMP, DONE
    } state_t;

    state_t state, state_nx;

    logic [IW-1:0]    pix;
    logic [ID_W-1:0]  face;
    logic [17:0]      taddr;
    logic [7:0]       p_reg;
    logic [SAD_W-1:0] acc;
    logic [8:0]       diff;
    logic [7:0]       absd;
    logic             rd_en;
    logic [17:0]      rd_add;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (start) state_nx = PROBE;
            PROBE:   state_nx = TMPL;
            TMPL:    state_nx = (pix == I_LAST) ? FIN : PROBE;
            FIN:     state_nx = CMP;
            CMP:     state_nx = (face == F_LAST) ? DONE : PROBE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        rd_en          = 1'b0;
        rd_add         = '0;
        busy           = 1'b0;
        face_sad_valid = 1'b0;
        face_sad       = '0;
        done           = 1'b0;
        unique case (state)
            PROBE: begin
                rd_en  = 1'b1;
                rd_add = 18'(PROBE_BASE) + 18'(pix);
                busy   = 1'b1;
            end
            TMPL: begin
                rd_en  = 1'b1;
                rd_add = taddr;
                busy   = 1'b1;
            end
            FIN:  busy = 1'b1;
            CMP: begin
                busy           = 1'b1;
                face_sad_valid = 1'b1;
                face_sad       = acc;
            end
            DONE:    done = 1'b1;
            default: ;
        endcase
    end

    assign mem.mem_r_en  = rd_en;
    assign mem.mem_r_add = rd_add;

    // Template byte arriving now is compared against the held probe byte.
    assign diff = {1'b0, p_reg} - {1'b0, mem.mem_r_data};
    assign absd = diff[8] ? (~diff[7:0] + 8'd1) : diff[7:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pix      <= '0;
            face     <= '0;
            taddr    <= '0;
            p_reg    <= '0;
            acc      <= '0;
            best_id  <= '0;
            best_sad <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        pix      <= '0;
                        face     <= '0;
                        taddr    <= '0;
                        acc      <= '0;
                        best_id  <= '0;
                        best_sad <= '1;
                    end
                end
                PROBE: begin
                    if (pix != '0) acc <= acc + SAD_W'(absd);
                end
                TMPL: begin
                    p_reg <= mem.mem_r_data;
                    taddr <= taddr + 18'd1;
                    if (pix != I_LAST) pix <= pix + 1'b1;
                end
                FIN: acc <= acc + SAD_W'(absd);
                CMP: begin
                    if (face == '0 || acc < best_sad) begin
                        best_sad <= acc;
                        best_id  <= face;
                    end
                    if (face != F_LAST) begin
                        face <= face + 1'b1;
                        pix  <= '0;
                        acc  <= '0;
                    end
                end
                DONE:    ;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_face_sad_matcher.sv
// Directed vector bench for face_sad_matcher with a registered memory model.
`timescale 1ns/1ps
module tb_face_sad_matcher;

    localparam int PIXELS     = 64;
    localparam int FACES      = 4;
    localparam int PROBE_BASE = FACES * PIXELS;
    localparam int ID_W       = 2;
    localparam int SAD_W      = 16;
    localparam int FACE_CYC   = 2 * PIXELS + 2;
    localparam int DONE_CYC   = FACES * FACE_CYC + 1;
    localparam int MEM_N      = PROBE_BASE + PIXELS;
    localparam int NV         = 6;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic             busy;
    logic             face_sad_valid;
    logic [SAD_W-1:0] face_sad;
    logic [ID_W-1:0]  best_id;
    logic [SAD_W-1:0] best_sad;
    logic             done;

    face_sad_matcher_if mif();

    face_sad_matcher #(
        .PIXELS(PIXELS), .FACES(FACES), .PROBE_BASE(PROBE_BASE),
        .ID_W(ID_W), .SAD_W(SAD_W)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .start(start),
        .mem(mif),
        .busy(busy),
        .face_sad_valid(face_sad_valid),
        .face_sad(face_sad),
        .best_id(best_id),
        .best_sad(best_sad),
        .done(done)
    );

    always #5 clk = ~clk;

    logic [7:0] img [MEM_N];

    always @(posedge clk) begin
        if (mif.mem_r_en) begin
            if (mif.mem_r_add < 18'(MEM_N))
                mif.mem_r_data <= img[mif.mem_r_add[8:0]];
            else
                mif.mem_r_data <= 8'h00;
        end
    end

    typedef struct packed {
        logic [7:0]       probe;
        logic [3:0][7:0]  tv;
        logic [3:0][7:0]  px0;
        logic [3:0][15:0] sad;
        logic [1:0]       bid;
        logic [15:0]      bsad;
    } vec_t;

    vec_t vecs [NV];
    int   errors = 0;
    int   checks = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic setv(input int n, input logic [7:0] p,
                        input logic [7:0] t0, input logic [7:0] t1,
                        input logic [7:0] t2, input logic [7:0] t3,
                        input logic [7:0] x0, input logic [7:0] x1,
                        input logic [7:0] x2, input logic [7:0] x3,
                        input int s0, input int s1, input int s2, input int s3,
                        input int bid, input int bsad);
        vecs[n].probe  = p;
        vecs[n].tv[0]  = t0;
        vecs[n].tv[1]  = t1;
        vecs[n].tv[2]  = t2;
        vecs[n].tv[3]  = t3;
        vecs[n].px0[0] = x0;
        vecs[n].px0[1] = x1;
        vecs[n].px0[2] = x2;
        vecs[n].px0[3] = x3;
        vecs[n].sad[0] = 16'(s0);
        vecs[n].sad[1] = 16'(s1);
        vecs[n].sad[2] = 16'(s2);
        vecs[n].sad[3] = 16'(s3);
        vecs[n].bid    = 2'(bid);
        vecs[n].bsad   = 16'(bsad);
    endtask

    task automatic load(input int v);
        for (int f = 0; f < FACES; f++)
            for (int i = 0; i < PIXELS; i++)
                img[f * PIXELS + i] = (i == 0) ? vecs[v].px0[f] : vecs[v].tv[f];
        for (int i = 0; i < PIXELS; i++)
            img[PROBE_BASE + i] = vecs[v].probe;
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_en"}, int'(mif.mem_r_en), 0);
        chk({tag, "_add"}, int'(mif.mem_r_add), 0);
        chk({tag, "_busy"}, int'(busy), 0);
        chk({tag, "_valid"}, int'(face_sad_valid), 0);
        chk({tag, "_face_sad"}, int'(face_sad), 0);
        chk({tag, "_best_id"}, int'(best_id), 0);
        chk({tag, "_best_sad"}, int'(best_sad), 0);
        chk({tag, "_done"}, int'(done), 0);
    endtask

    task automatic run(input int v, input int mid_start,
                       input int abort_cyc, input bit done_start);
        int bad;
        int first_bad;
        int f;
        int k;
        int e_en;
        int e_add;
        int e_busy;
        int e_valid;
        int e_done;
        bad = 0;
        first_bad = 0;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        for (int c = 1; c <= DONE_CYC; c++) begin
            @(negedge clk);
            if (c == abort_cyc) begin
                rst_n = 1'b0;
                #1;
                check_zero("abort");
                @(negedge clk);
                rst_n = 1'b1;
                return;
            end
            f = (c - 1) / FACE_CYC;
            k = (c - 1) % FACE_CYC;
            e_en = 0; e_add = 0; e_busy = 0; e_valid = 0; e_done = 0;
            if (c == DONE_CYC) begin
                e_done = 1;
            end else begin
                e_busy = 1;
                if (k < 2 * PIXELS) begin
                    e_en = 1;
                    e_add = (k % 2 == 0) ? PROBE_BASE + k / 2
                                         : f * PIXELS + k / 2;
                end
                e_valid = (k == FACE_CYC - 1) ? 1 : 0;
            end
            if (int'(mif.mem_r_en) != e_en || int'(busy) != e_busy ||
                int'(face_sad_valid) != e_valid || int'(done) != e_done ||
                (e_en == 1 && int'(mif.mem_r_add) != e_add)) begin
                bad++;
                if (first_bad == 0) first_bad = c;
            end
            if (e_valid == 1)
                chk($sformatf("face_sad_v%0d_f%0d", v, f),
                    int'(face_sad), int'(vecs[v].sad[f]));
            start = (c == mid_start || (done_start && c == DONE_CYC));
        end
        chk($sformatf("seq_v%0d_firstbad%0d", v, first_bad), bad, 0);
        chk($sformatf("best_id_v%0d", v), int'(best_id), int'(vecs[v].bid));
        chk($sformatf("best_sad_v%0d", v), int'(best_sad), int'(vecs[v].bsad));
        if (done_start) begin
            @(posedge clk);
            #1 start = 1'b0;
            @(negedge clk);
            chk("done_start_busy", int'(busy), 0);
            chk("done_start_en", int'(mif.mem_r_en), 0);
        end else begin
            repeat (3) @(negedge clk);
            chk($sformatf("hold_id_v%0d", v), int'(best_id), int'(vecs[v].bid));
            chk($sformatf("hold_sad_v%0d", v), int'(best_sad), int'(vecs[v].bsad));
            chk($sformatf("hold_busy_v%0d", v), int'(busy), 0);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < MEM_N; i++) img[i] = 8'h00;
        setv(0, 8'h55, 8'h55, 8'h55, 8'h55, 8'h55, 8'h55, 8'h55, 8'h55, 8'h55,
             0, 0, 0, 0, 0, 0);
        setv(1, 8'h00, 8'h40, 8'h30, 8'h20, 8'h10, 8'h40, 8'h30, 8'h20, 8'h10,
             4096, 3072, 2048, 1024, 3, 1024);
        setv(2, 8'h00, 8'h10, 8'h00, 8'h01, 8'h02, 8'h10, 8'd100, 8'd37, 8'h02,
             1024, 100, 100, 128, 1, 100);
        setv(3, 8'h00, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF,
             16320, 16320, 16320, 16320, 0, 16320);
        setv(4, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
             16320, 16320, 16320, 16320, 0, 16320);
        setv(5, 8'h80, 8'h7F, 8'h81, 8'h00, 8'hFF, 8'h7F, 8'h81, 8'h00, 8'hFF,
             64, 64, 8192, 8128, 0, 64);

        repeat (3) @(negedge clk);
        check_zero("reset");
        rst_n = 1'b1;
        @(negedge clk);

        for (int v = 0; v < NV; v++) begin
            load(v);
            run(v, 0, 0, 1'b0);
        end

        load(1);
        run(1, 200, 0, 1'b1);
        load(2);
        run(2, 0, 0, 1'b0);

        load(1);
        run(1, 0, 2 * FACE_CYC + 50, 1'b0);
        load(3);
        run(3, 0, 0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
